// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding command master: turns one cmd_* request into an
// AXI-Lite read or write and returns the outcome on rsp_*, with a per-transaction abort timer.
module axil_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_aresetn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t                        state_r, state_nxt;
    logic                          cmd_ready_r, cmd_ready_nxt;
    logic                          awvalid_r, awvalid_nxt;
    logic                          wvalid_r, wvalid_nxt;
    logic                          bready_r, bready_nxt;
    logic                          arvalid_r, arvalid_nxt;
    logic                          rready_r, rready_nxt;
    logic                          rsp_valid_r, rsp_valid_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data_r, rsp_data_nxt;
    logic [1:0]                    rsp_resp_r, rsp_resp_nxt;
    logic                          rsp_timeout_r, rsp_timeout_nxt;
    logic [CNT_W-1:0]              cnt_r, cnt_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_r, addr_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_r, wdata_nxt;
    logic [STRB_W-1:0]             wstrb_r, wstrb_nxt;

    logic aw_clear_s, w_clear_s, ar_clear_s;
    logic aw_hs_s, w_hs_s, b_hs_s, r_hs_s, expire_s;

    // An address/data channel counts as finished once its handshake is done or happens this cycle.
    assign aw_clear_s = ~awvalid_r | m_axi_awready;
    assign w_clear_s  = ~wvalid_r  | m_axi_wready;
    assign ar_clear_s = ~arvalid_r | m_axi_arready;
    assign aw_hs_s    = awvalid_r & m_axi_awready;
    assign w_hs_s     = wvalid_r  & m_axi_wready;
    assign expire_s   = (cnt_r == CNT_LAST);

    // Response readies are gated so B/R can never complete ahead of their address/data handshakes.
    assign m_axi_bready = bready_r & aw_clear_s & w_clear_s;
    assign m_axi_rready = rready_r & ar_clear_s;
    assign b_hs_s       = m_axi_bready & m_axi_bvalid;
    assign r_hs_s       = m_axi_rready & m_axi_rvalid;

    assign cmd_ready     = cmd_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_resp      = rsp_resp_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_araddr  = addr_r;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_arvalid = arvalid_r;

    // Next-state and next-output decode; every register holds unless a branch says otherwise.
    always_comb begin
        state_nxt       = state_r;
        cmd_ready_nxt   = cmd_ready_r;
        awvalid_nxt     = awvalid_r;
        wvalid_nxt      = wvalid_r;
        bready_nxt      = bready_r;
        arvalid_nxt     = arvalid_r;
        rready_nxt      = rready_r;
        rsp_valid_nxt   = rsp_valid_r;
        rsp_data_nxt    = rsp_data_r;
        rsp_resp_nxt    = rsp_resp_r;
        rsp_timeout_nxt = rsp_timeout_r;
        cnt_nxt         = cnt_r;
        addr_nxt        = addr_r;
        wdata_nxt       = wdata_r;
        wstrb_nxt       = wstrb_r;

        case (state_r)
            IDLE: begin
                cmd_ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready_r) begin
                    cmd_ready_nxt = 1'b0;
                    cnt_nxt       = {CNT_W{1'b0}};
                    addr_nxt      = cmd_addr;
                    wdata_nxt     = cmd_wdata;
                    wstrb_nxt     = cmd_wstrb;
                    if (cmd_write) begin
                        state_nxt   = WR;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        bready_nxt  = 1'b1;
                    end else begin
                        state_nxt   = RD;
                        arvalid_nxt = 1'b1;
                        rready_nxt  = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WR: begin
                if (aw_hs_s) begin
                    awvalid_nxt = 1'b0;
                end else begin
                    awvalid_nxt = awvalid_r;
                end
                if (w_hs_s) begin
                    wvalid_nxt = 1'b0;
                end else begin
                    wvalid_nxt = wvalid_r;
                end
                // Completion wins over expiry when both land in the same cycle.
                if (b_hs_s) begin
                    state_nxt       = RSP;
                    awvalid_nxt     = 1'b0;
                    wvalid_nxt      = 1'b0;
                    bready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_data_nxt    = {C_M_AXI_DATA_WIDTH{1'b0}};
                    rsp_resp_nxt    = m_axi_bresp;
                    rsp_timeout_nxt = 1'b0;
                end else if (expire_s) begin
                    state_nxt       = RSP;
                    awvalid_nxt     = 1'b0;
                    wvalid_nxt      = 1'b0;
                    bready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_data_nxt    = {C_M_AXI_DATA_WIDTH{1'b0}};
                    rsp_resp_nxt    = RESP_SLVERR;
                    rsp_timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            RD: begin
                if (m_axi_arready) begin
                    arvalid_nxt = 1'b0;
                end else begin
                    arvalid_nxt = arvalid_r;
                end
                if (r_hs_s) begin
                    state_nxt       = RSP;
                    arvalid_nxt     = 1'b0;
                    rready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_data_nxt    = m_axi_rdata;
                    rsp_resp_nxt    = m_axi_rresp;
                    rsp_timeout_nxt = 1'b0;
                end else if (expire_s) begin
                    state_nxt       = RSP;
                    arvalid_nxt     = 1'b0;
                    rready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_data_nxt    = {C_M_AXI_DATA_WIDTH{1'b0}};
                    rsp_resp_nxt    = RESP_SLVERR;
                    rsp_timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                    cmd_ready_nxt = 1'b1;
                end else begin
                    state_nxt = RSP;
                end
            end
            default: begin
                state_nxt     = IDLE;
                cmd_ready_nxt = 1'b0;
                awvalid_nxt   = 1'b0;
                wvalid_nxt    = 1'b0;
                bready_nxt    = 1'b0;
                arvalid_nxt   = 1'b0;
                rready_nxt    = 1'b0;
                rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Output, capture and timer registers; reset drops any in-flight transaction silently.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            cmd_ready_r   <= 1'b0;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            bready_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_data_r    <= {C_M_AXI_DATA_WIDTH{1'b0}};
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
            addr_r        <= {C_M_AXI_ADDR_WIDTH{1'b0}};
            wdata_r       <= {C_M_AXI_DATA_WIDTH{1'b0}};
            wstrb_r       <= {STRB_W{1'b0}};
        end else begin
            cmd_ready_r   <= cmd_ready_nxt;
            awvalid_r     <= awvalid_nxt;
            wvalid_r      <= wvalid_nxt;
            bready_r      <= bready_nxt;
            arvalid_r     <= arvalid_nxt;
            rready_r      <= rready_nxt;
            rsp_valid_r   <= rsp_valid_nxt;
            rsp_data_r    <= rsp_data_nxt;
            rsp_resp_r    <= rsp_resp_nxt;
            rsp_timeout_r <= rsp_timeout_nxt;
            cnt_r         <= cnt_nxt;
            addr_r        <= addr_nxt;
            wdata_r       <= wdata_nxt;
            wstrb_r       <= wstrb_nxt;
        end
    end

endmodule
